// File: rtl/calculator_pkg.sv
// Shared calculator types and helpers: converter state encoding, digit sizing,
// and the reference binary-to-BCD conversion used by benches.
package calculator_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;

    // ceil(bits * log10(2)) in fixed point; log10(2) ~= 0.30103
    function automatic int digits_for_bits(int bits);
        longint scaled;
        scaled = longint'(bits) * 64'sd30103;
        return int'((scaled + 64'sd99999) / 64'sd100000);
    endfunction

    function automatic logic [127:0] bin_to_bcd(input longint unsigned value, input int digits);
        logic [127:0] res;
        longint unsigned v;
        res = '0;
        v   = value;
        for (int i = 0; i < digits && i < 32; i++) begin
            res[4*i +: 4] = 4'(v % 64'd10);
            v             = v / 64'd10;
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3 before the shift.
module bcd_digit_adj (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bcd_converter.sv
// Iterative binary-to-BCD converter, one double-dabble step per clock, with
// valid/ready handshakes and optional sign/magnitude handling.
//
//   state | meaning
//   IDLE  | in_ready high, waiting for an operand
//   SHIFT | one adjust+shift step per cycle, BITS steps total
//   DONE  | out_valid high, result held until out_ready
module bcd_converter
    import calculator_pkg::*;
#(
    parameter int BITS   = 32,
    parameter int DIGITS = 10,
    parameter bit SIGNED = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BITS-1:0]       in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIGITS*4-1:0]   out_bcd,
    output logic                  out_sign,
    output logic                  out_overflow
);

    localparam int CNT_W = $clog2(BITS + 1);
    localparam int ACC_W = 4 * DIGITS;

    bcd_state_t        state, state_next;
    logic [BITS-1:0]   operand;
    logic [ACC_W-1:0]  acc, acc_adj;
    logic [CNT_W-1:0]  cnt;
    logic              sign, overflow;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit    (acc[4*g +: 4]),
            .adjusted (acc_adj[4*g +: 4])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)             state_next = SHIFT;
            SHIFT:   if (cnt == CNT_W'(1))     state_next = DONE;
            DONE:    if (out_ready)            state_next = IDLE;
            default:                           state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            operand  <= '0;
            acc      <= '0;
            cnt      <= '0;
            sign     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Negation of the most negative value yields 2^(BITS-1), still correct unsigned.
                        if (SIGNED && in_data[BITS-1]) begin
                            operand <= -in_data;
                            sign    <= 1'b1;
                        end else begin
                            operand <= in_data;
                            sign    <= 1'b0;
                        end
                        acc      <= '0;
                        overflow <= 1'b0;
                        cnt      <= CNT_W'(BITS);
                    end
                end
                SHIFT: begin
                    acc      <= {acc_adj[ACC_W-2:0], operand[BITS-1]};
                    operand  <= {operand[BITS-2:0], 1'b0};
                    overflow <= overflow | acc_adj[ACC_W-1];
                    cnt      <= cnt - CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready     = (state == IDLE);
    assign out_valid    = (state == DONE);
    assign out_bcd      = acc;
    assign out_sign     = sign;
    assign out_overflow = overflow;

endmodule

// File: tb/tb_bcd_converter.sv
// Bench for bcd_converter: three configurations, table vectors plus randomized
// and back-to-back traffic checked through an expectation queue.
module tb_bcd_converter;
    import calculator_pkg::*;

    typedef struct {
        logic [39:0] bcd;
        logic        sign;
        logic        ovf;
    } exp_t;

    typedef struct {
        int          inst;
        logic [31:0] din;
        logic [39:0] bcd;
        logic        sign;
        logic        ovf;
        int          hold;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // inst 0: defaults (32/10/unsigned)
    logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0;
    logic [31:0] a_in_data = '0;
    logic [39:0] a_out_bcd;
    logic        a_out_sign, a_out_ovf;
    // inst 1: 8 bits, 3 digits, signed
    logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0;
    logic [7:0]  b_in_data = '0;
    logic [11:0] b_out_bcd;
    logic        b_out_sign, b_out_ovf;
    // inst 2: 8 bits, 2 digits, unsigned
    logic        c_in_valid = 1'b0, c_in_ready, c_out_valid, c_out_ready = 1'b0;
    logic [7:0]  c_in_data = '0;
    logic [7:0]  c_out_bcd;
    logic        c_out_sign, c_out_ovf;

    bcd_converter u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_bcd(a_out_bcd), .out_sign(a_out_sign), .out_overflow(a_out_ovf)
    );

    bcd_converter #(.BITS(8), .DIGITS(3), .SIGNED(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_bcd(b_out_bcd), .out_sign(b_out_sign), .out_overflow(b_out_ovf)
    );

    bcd_converter #(.BITS(8), .DIGITS(2), .SIGNED(1'b0)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_bcd(c_out_bcd), .out_sign(c_out_sign), .out_overflow(c_out_ovf)
    );

    int n_vec = 0;
    int n_fail = 0;

    exp_t        q[$];
    int          cur_inst = 0;
    logic        cur_v = 1'b0, cur_r = 1'b0;
    logic [31:0] cur_d = '0;
    exp_t        cur_exp;
    int          cyc = 0;
    bit          busy = 0, rel_next = 0, lat_pending = 0, acc_flag = 0;
    bit          hold_chk = 0, chk_interval = 0, have_last = 0;
    int          lat_start = 0, last_acc = 0, done_cnt = 0;
    logic [39:0] held_bcd;
    logic        held_sign, held_ovf;

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d, inst %0d)", name, got, want, cyc, cur_inst);
        end
    endtask

    task automatic fail_msg(input string name);
        n_vec++;
        n_fail++;
        $display("FAIL %s (cycle %0d, inst %0d)", name, cyc, cur_inst);
    endtask

    function automatic int bits_of(int inst);
        return (inst == 0) ? 32 : 8;
    endfunction

    function automatic exp_t model(int inst, logic [31:0] d);
        exp_t e;
        longint unsigned mag, lim;
        int digs;
        logic [127:0] full;
        digs   = (inst == 0) ? 10 : ((inst == 1) ? 3 : 2);
        mag    = (inst == 0) ? {32'b0, d} : {56'b0, d[7:0]};
        e.sign = 1'b0;
        if (inst == 1 && d[7]) begin
            mag    = 64'd256 - mag;
            e.sign = 1'b1;
        end
        lim = 64'd1;
        for (int i = 0; i < digs; i++) lim = lim * 64'd10;
        e.ovf = (mag >= lim);
        full  = bin_to_bcd(mag, digs);
        e.bcd = full[39:0];
        return e;
    endfunction

    function automatic logic [31:0] pick(int inst);
        int sel;
        logic [31:0] r;
        sel = $urandom_range(0, 7);
        r   = $urandom;
        case (sel)
            0: r = '0;
            1: r = (inst == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
            2: r = (inst == 0) ? 32'h8000_0000 : 32'h0000_0080;
            default: r = (inst == 0) ? r : {24'b0, r[7:0]};
        endcase
        return r;
    endfunction

    task automatic apply();
        case (cur_inst)
            0: begin a_in_valid = cur_v; a_in_data = cur_d;      a_out_ready = cur_r; end
            1: begin b_in_valid = cur_v; b_in_data = cur_d[7:0]; b_out_ready = cur_r; end
            default: begin c_in_valid = cur_v; c_in_data = cur_d[7:0]; c_out_ready = cur_r; end
        endcase
    endtask

    task automatic get_st(input int inst, output logic irdy, output logic ovld,
                          output logic [39:0] bcd, output logic sgn, output logic ovf);
        case (inst)
            0: begin irdy = a_in_ready; ovld = a_out_valid; bcd = a_out_bcd;         sgn = a_out_sign; ovf = a_out_ovf; end
            1: begin irdy = b_in_ready; ovld = b_out_valid; bcd = {28'b0, b_out_bcd}; sgn = b_out_sign; ovf = b_out_ovf; end
            default: begin irdy = c_in_ready; ovld = c_out_valid; bcd = {32'b0, c_out_bcd}; sgn = c_out_sign; ovf = c_out_ovf; end
        endcase
    endtask

    // One cycle: observe outputs at the negedge with this cycle's inputs already driven.
    task automatic tick();
        logic irdy, ovld, sgn, ovf;
        logic [39:0] bcd;
        exp_t e;
        get_st(cur_inst, irdy, ovld, bcd, sgn, ovf);
        chk("ready_valid_exclusive", {63'b0, irdy & ovld}, 64'd0);
        if (busy) begin
            chk("in_ready_while_busy", {63'b0, irdy}, {63'b0, rel_next});
            if (rel_next) begin
                busy     = 0;
                rel_next = 0;
            end
        end
        if (hold_chk && ovld) begin
            chk("hold_bcd", {24'b0, bcd}, {24'b0, held_bcd});
            chk("hold_flags", {62'b0, sgn, ovf}, {62'b0, held_sign, held_ovf});
        end
        if (lat_pending && ovld) begin
            chk("latency", 64'(cyc - lat_start), 64'(bits_of(cur_inst) + 1));
            lat_pending = 0;
        end
        if (cur_v && irdy) begin
            q.push_back(cur_exp);
            busy        = 1;
            lat_pending = 1;
            lat_start   = cyc;
            acc_flag    = 1;
            if (chk_interval && have_last)
                chk("issue_interval", 64'(cyc - last_acc), 64'(bits_of(cur_inst) + 2));
            have_last = 1;
            last_acc  = cyc;
        end
        if (ovld && cur_r) begin
            if (q.size() == 0) begin
                fail_msg("spurious_output");
            end else begin
                e = q.pop_front();
                chk("out_bcd", {24'b0, bcd}, {24'b0, e.bcd});
                chk("out_sign", {63'b0, sgn}, {63'b0, e.sign});
                chk("out_overflow", {63'b0, ovf}, {63'b0, e.ovf});
                done_cnt++;
                rel_next = 1;
            end
        end
        hold_chk  = ovld && !cur_r;
        held_bcd  = bcd;
        held_sign = sgn;
        held_ovf  = ovf;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic convert(input int inst, input logic [31:0] d, input exp_t e, input int hold);
        int n;
        cur_inst = inst;
        cur_v    = 1'b1;
        cur_d    = d;
        cur_exp  = e;
        cur_r    = (hold == 0);
        acc_flag = 0;
        apply();
        n = 0;
        while (!acc_flag && n < 50) begin
            tick();
            n++;
        end
        if (!acc_flag) fail_msg("accept_timeout");
        cur_v = 1'b0;
        apply();
        n = 0;
        while (q.size() > 0 && n < 400) begin
            if (n >= hold) cur_r = 1'b1;
            apply();
            tick();
            n++;
        end
        if (q.size() > 0) fail_msg("result_timeout");
        q.delete();
        cur_r = 1'b0;
        apply();
        tick();
    endtask

    task automatic random_phase(input int inst, input int n_results, input bit b2b);
        int c;
        cur_inst     = inst;
        done_cnt     = 0;
        chk_interval = b2b;
        have_last    = 0;
        c            = 0;
        while (done_cnt < n_results && c < n_results * 200) begin
            cur_v   = b2b ? 1'b1 : ($urandom_range(0, 3) != 0);
            cur_d   = pick(inst);
            cur_exp = model(inst, cur_d);
            cur_r   = b2b ? 1'b1 : 1'($urandom_range(0, 1));
            apply();
            tick();
            c++;
        end
        if (done_cnt < n_results) fail_msg("random_phase_timeout");
        cur_v = 1'b0;
        cur_r = 1'b1;
        chk_interval = 0;
        apply();
        c = 0;
        while ((q.size() > 0 || busy) && c < 100) begin
            tick();
            c++;
        end
        if (q.size() > 0) fail_msg("drain_timeout");
        q.delete();
        cur_r = 1'b0;
        apply();
    endtask

    vec_t vt[12];

    initial begin
        logic irdy, ovld, sgn, ovf;
        logic [39:0] bcd;

        vt[0]  = '{1, 32'h80,        40'h128,        1'b1, 1'b0, 0};
        vt[1]  = '{1, 32'hFF,        40'h001,        1'b1, 1'b0, 0};
        vt[2]  = '{1, 32'h7F,        40'h127,        1'b0, 1'b0, 0};
        vt[3]  = '{1, 32'h00,        40'h000,        1'b0, 1'b0, 0};
        vt[4]  = '{1, 32'h81,        40'h127,        1'b1, 1'b0, 3};
        vt[5]  = '{2, 32'd255,       40'h55,         1'b0, 1'b1, 0};
        vt[6]  = '{2, 32'd99,        40'h99,         1'b0, 1'b0, 0};
        vt[7]  = '{2, 32'd100,       40'h00,         1'b0, 1'b1, 14};
        vt[8]  = '{0, 32'hFFFF_FFFF, 40'h4294967295, 1'b0, 1'b0, 0};
        vt[9]  = '{0, 32'd0,         40'h0,          1'b0, 1'b0, 0};
        vt[10] = '{0, 32'h3B9A_CA00, 40'h1000000000, 1'b0, 1'b0, 45};
        vt[11] = '{0, 32'hFF,        40'h255,        1'b0, 1'b0, 40};

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            cur_inst = i;
            get_st(i, irdy, ovld, bcd, sgn, ovf);
            chk("reset_in_ready", {63'b0, irdy}, 64'd1);
            chk("reset_out_valid", {63'b0, ovld}, 64'd0);
            chk("reset_out_bcd", {24'b0, bcd}, 64'd0);
            chk("reset_out_sign", {63'b0, sgn}, 64'd0);
            chk("reset_out_overflow", {63'b0, ovf}, 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++)
            convert(vt[i].inst, vt[i].din, '{vt[i].bcd, vt[i].sign, vt[i].ovf}, vt[i].hold);

        // Reset pulse during SHIFT on the signed instance, then a clean conversion.
        cur_inst = 1;
        cur_v    = 1'b1;
        cur_d    = 32'h85;
        cur_exp  = model(1, 32'h85);
        cur_r    = 1'b1;
        acc_flag = 0;
        apply();
        for (int n = 0; n < 10 && !acc_flag; n++) tick();
        cur_v = 1'b0;
        apply();
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        get_st(1, irdy, ovld, bcd, sgn, ovf);
        chk("abort_in_ready", {63'b0, irdy}, 64'd1);
        chk("abort_out_valid", {63'b0, ovld}, 64'd0);
        chk("abort_out_bcd", {24'b0, bcd}, 64'd0);
        chk("abort_out_sign", {63'b0, sgn}, 64'd0);
        chk("abort_out_overflow", {63'b0, ovf}, 64'd0);
        q.delete();
        busy = 0; rel_next = 0; lat_pending = 0; hold_chk = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) tick();
        convert(1, 32'h85, model(1, 32'h85), 0);

        random_phase(0, 20, 1'b1);
        random_phase(0, 500, 1'b0);
        random_phase(1, 300, 1'b0);
        random_phase(2, 300, 1'b0);
        random_phase(1, 10, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
